// File: rtl/wb_pkg.sv
// White-balance shared definitions: CFA layout codes, colour channels, pixel-to-channel map.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package wb_pkg;

  // Bayer layouts, named by the colours of row 0 col 0 and row 0 col 1 followed by row 1.
  typedef enum logic [1:0] {
    CFA_GRBG = 2'b00,
    CFA_RGGB = 2'b01,
    CFA_BGGR = 2'b10,
    CFA_GBRG = 2'b11
  } cfa_e;

  // Gain channels. Gr is green sharing a row with red, Gb is green sharing a row with blue.
  typedef enum logic [1:0] {
    CH_R  = 2'b00,
    CH_GR = 2'b01,
    CH_GB = 2'b10,
    CH_B  = 2'b11
  } ch_e;

  // Channel of the pixel at (row parity, column parity) for a given layout.
  function automatic ch_e cfa_ch(input logic [1:0] cfa, input logic row, input logic col);
    ch_e ch;
    ch = CH_R;
    case (cfa)
      CFA_GRBG: begin
        case ({row, col})
          2'b00:   ch = CH_GR;
          2'b01:   ch = CH_R;
          2'b10:   ch = CH_B;
          default: ch = CH_GB;
        endcase
      end
      CFA_RGGB: begin
        case ({row, col})
          2'b00:   ch = CH_R;
          2'b01:   ch = CH_GR;
          2'b10:   ch = CH_GB;
          default: ch = CH_B;
        endcase
      end
      CFA_BGGR: begin
        case ({row, col})
          2'b00:   ch = CH_B;
          2'b01:   ch = CH_GB;
          2'b10:   ch = CH_GR;
          default: ch = CH_R;
        endcase
      end
      default: begin
        case ({row, col})
          2'b00:   ch = CH_GB;
          2'b01:   ch = CH_B;
          2'b10:   ch = CH_R;
          default: ch = CH_GR;
        endcase
      end
    endcase
    return ch;
  endfunction

endpackage

// File: rtl/wb_gain_lane.sv
// One-pixel gain datapath: multiply, round-to-nearest, saturating clip, saturation flag.
// Latency: 2 cycles (product register, then rounded/clipped result register).
// Backpressure: none; accepts a pixel every cycle.
module wb_gain_lane #(
  parameter int DW_IN   = 10,
  parameter int DW_GAIN = 10,
  parameter int DW_DEC  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [DW_IN-1:0]   i_pix,
  input  logic [DW_GAIN-1:0] i_gain,
  input  logic               i_en,
  output logic [DW_IN-1:0]   o_pix,
  output logic               o_sat
);

  localparam int PW = DW_IN + DW_GAIN;
  // Width of the product after dropping the fractional bits (one carry bit from rounding).
  localparam int RW = PW + 1 - DW_DEC;
  localparam logic [PW:0]   HALF = {{PW{1'b0}}, 1'b1} << (DW_DEC - 1);
  localparam logic [RW-1:0] MAXV = {{(RW - DW_IN){1'b0}}, {DW_IN{1'b1}}};

  logic [PW-1:0]    r_prod;
  logic [DW_IN-1:0] r_pix;
  logic             r_en;
  logic [DW_IN-1:0] r_out;
  logic             r_sat;

  logic [PW:0]      w_rnd;
  logic [RW-1:0]    w_q;
  logic             w_ovf;

  // Stage 1: full-precision product, with the raw pixel kept for bypass.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_prod <= '0;
      r_pix  <= '0;
      r_en   <= 1'b0;
    end else begin
      r_prod <= {{DW_GAIN{1'b0}}, i_pix} * {{DW_IN{1'b0}}, i_gain};
      r_pix  <= i_pix;
      r_en   <= i_en;
    end
  end

  // Add half an LSB of the output scale, drop fractional bits, detect overflow.
  always_comb begin
    w_rnd = {1'b0, r_prod} + HALF;
    w_q   = RW'(w_rnd >> DW_DEC);
    w_ovf = (w_q > MAXV);
  end

  // Stage 2: clip to full scale when gaining, otherwise pass the pixel untouched.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out <= '0;
      r_sat <= 1'b0;
    end else if (!r_en) begin
      r_out <= r_pix;
      r_sat <= 1'b0;
    end else if (w_ovf) begin
      r_out <= {DW_IN{1'b1}};
      r_sat <= 1'b1;
    end else begin
      r_out <= w_q[DW_IN-1:0];
      r_sat <= 1'b0;
    end
  end

  assign o_pix = r_out;
  assign o_sat = r_sat;

endmodule

// File: rtl/wb_gain_ppc.sv
// Bayer white-balance gain, PPC pixels/clock, frame-shadowed config, per-frame saturation count.
// Latency: 2 cycles for data and syncs; sat_cnt reported 1 cycle after vsync_out falls.
// Backpressure: none; one beat per cycle, never stalls.
module wb_gain_ppc
  import wb_pkg::*;
#(
  parameter int DW_IN   = 10,
  parameter int DW_GAIN = 10,
  parameter int DW_DEC  = 8,
  parameter int PPC     = 2,
  parameter int DW_CNT  = 20
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           CFA,
  input  logic                 wb_en,
  input  logic                 vsync_in,
  input  logic                 hsync_in,
  input  logic [DW_IN*PPC-1:0] data_in,
  input  logic [DW_GAIN-1:0]   R_gain,
  input  logic [DW_GAIN-1:0]   Gr_gain,
  input  logic [DW_GAIN-1:0]   Gb_gain,
  input  logic [DW_GAIN-1:0]   B_gain,
  output logic                 vsync_out,
  output logic                 hsync_out,
  output logic [DW_IN*PPC-1:0] data_out,
  output logic [DW_CNT-1:0]    sat_cnt,
  output logic                 sat_cnt_vld
);

  localparam logic [DW_GAIN-1:0] UNITY = {{(DW_GAIN-1){1'b0}}, 1'b1} << DW_DEC;
  localparam int SW = $clog2(PPC + 1);

  // Frame-shadowed configuration.
  logic [1:0]         r_cfa;
  logic               r_en;
  logic [DW_GAIN-1:0] r_gain_r;
  logic [DW_GAIN-1:0] r_gain_gr;
  logic [DW_GAIN-1:0] r_gain_gb;
  logic [DW_GAIN-1:0] r_gain_b;

  // Input-side edge detection and Bayer position.
  logic r_vs_prev;
  logic r_hs_prev;
  logic r_frame;
  logic r_row;
  logic r_col;

  // Sync pipeline; r_fv* marks beats belonging to a frame whose start was seen.
  logic r_vs1, r_hs1, r_fv1;
  logic r_vs2, r_hs2, r_fv2;
  logic r_vs3, r_fv3;

  // Saturation statistics.
  logic [DW_CNT-1:0] r_acc;
  logic [DW_CNT-1:0] r_sat_cnt;
  logic              r_sat_vld;

  logic              w_vs_rise;
  logic              w_hs_fall;
  logic              w_vo_fall;
  logic [PPC-1:0]    w_sat;
  logic [SW-1:0]     w_sat_sum;
  logic [SW-1:0]     w_add;
  logic [DW_CNT:0]   w_acc_sum;
  logic [DW_CNT-1:0] w_acc_nxt;

  assign w_vs_rise = vsync_in & ~r_vs_prev;
  assign w_hs_fall = r_hs_prev & ~hsync_in;
  assign w_vo_fall = r_vs3 & ~r_vs2;

  // Shadow capture on frame start and row/column parity tracking.
  // r_vs_prev resets high so a vsync held high through reset is not taken as a new frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cfa     <= 2'b00;
      r_en      <= 1'b0;
      r_gain_r  <= UNITY;
      r_gain_gr <= UNITY;
      r_gain_gb <= UNITY;
      r_gain_b  <= UNITY;
      r_vs_prev <= 1'b1;
      r_hs_prev <= 1'b0;
      r_frame   <= 1'b0;
      r_row     <= 1'b0;
      r_col     <= 1'b0;
    end else begin
      r_vs_prev <= vsync_in;
      r_hs_prev <= hsync_in;
      if (w_vs_rise) begin
        r_cfa     <= CFA;
        r_en      <= wb_en;
        r_gain_r  <= R_gain;
        r_gain_gr <= Gr_gain;
        r_gain_gb <= Gb_gain;
        r_gain_b  <= B_gain;
        r_frame   <= 1'b1;
        r_row     <= 1'b0;
      end else begin
        if (!vsync_in) begin
          r_frame <= 1'b0;
        end
        if (w_hs_fall) begin
          r_row <= ~r_row;
        end
      end
      // Only meaningful for PPC=1; wider beats always start on an even column.
      r_col <= hsync_in ? ~r_col : 1'b0;
    end
  end

  // Per-lane gain selection and datapath.
  for (genvar i = 0; i < PPC; i++) begin : g_lane
    // Lane 0 is the leftmost pixel, packed in the most significant slice.
    localparam int   LO   = (PPC - 1 - i) * DW_IN;
    localparam logic COLP = ((i % 2) == 1);

    logic               w_col;
    logic [DW_GAIN-1:0] w_gain;

    assign w_col = (PPC == 1) ? r_col : COLP;

    // Pick this lane's gain from its Bayer channel.
    always_comb begin
      w_gain = r_gain_r;
      case (cfa_ch(r_cfa, r_row, w_col))
        CH_R:    w_gain = r_gain_r;
        CH_GR:   w_gain = r_gain_gr;
        CH_GB:   w_gain = r_gain_gb;
        default: w_gain = r_gain_b;
      endcase
    end

    wb_gain_lane #(
      .DW_IN  (DW_IN),
      .DW_GAIN(DW_GAIN),
      .DW_DEC (DW_DEC)
    ) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .i_pix (data_in[LO +: DW_IN]),
      .i_gain(w_gain),
      .i_en  (r_en),
      .o_pix (data_out[LO +: DW_IN]),
      .o_sat (w_sat[i])
    );
  end

  // Delay syncs to match the two datapath stages.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vs1 <= 1'b0;
      r_hs1 <= 1'b0;
      r_fv1 <= 1'b0;
      r_vs2 <= 1'b0;
      r_hs2 <= 1'b0;
      r_fv2 <= 1'b0;
      r_vs3 <= 1'b0;
      r_fv3 <= 1'b0;
    end else begin
      r_vs1 <= vsync_in;
      r_hs1 <= hsync_in;
      r_fv1 <= vsync_in & (r_frame | w_vs_rise);
      r_vs2 <= r_vs1;
      r_hs2 <= r_hs1;
      r_fv2 <= r_fv1;
      r_vs3 <= r_vs2;
      r_fv3 <= r_fv2;
    end
  end

  // Count saturated pixels of active output beats, saturating the accumulator.
  always_comb begin
    w_sat_sum = '0;
    for (int k = 0; k < PPC; k++) begin
      w_sat_sum = w_sat_sum + SW'(w_sat[k]);
    end
    w_add     = r_hs2 ? w_sat_sum : '0;
    w_acc_sum = {1'b0, r_acc} + {{(DW_CNT + 1 - SW){1'b0}}, w_add};
    w_acc_nxt = w_acc_sum[DW_CNT] ? {DW_CNT{1'b1}} : w_acc_sum[DW_CNT-1:0];
  end

  // Report at output frame end; a frame cut short by reset is cleared without a report.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc     <= '0;
      r_sat_cnt <= '0;
      r_sat_vld <= 1'b0;
    end else if (w_vo_fall) begin
      r_acc     <= '0;
      r_sat_vld <= r_fv3;
      if (r_fv3) begin
        r_sat_cnt <= w_acc_nxt;
      end
    end else begin
      r_acc     <= w_acc_nxt;
      r_sat_vld <= 1'b0;
    end
  end

  assign vsync_out   = r_vs2;
  assign hsync_out   = r_hs2;
  assign sat_cnt     = r_sat_cnt;
  assign sat_cnt_vld = r_sat_vld;

endmodule

// File: tb/tb_wb_gain_ppc.sv
module tb_wb_gain_ppc;

  localparam int NMAX = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  cfa;
  logic        wb_en;
  logic        vsync_in;
  logic        hsync_in;
  logic [19:0] data_in;
  logic [9:0]  r_gain, gr_gain, gb_gain, b_gain;
  logic        vsync_out;
  logic        hsync_out;
  logic [19:0] data_out;
  logic [19:0] sat_cnt;
  logic        sat_cnt_vld;

  int total = 0;
  int bad   = 0;

  // Stimulus script and aligned captures (cap_*[i] = outputs belonging to beat i).
  logic        st_vs [NMAX];
  logic        st_hs [NMAX];
  logic [19:0] st_d  [NMAX];
  int          n_st;
  logic [19:0] cap_d   [NMAX];
  logic        cap_vs  [NMAX];
  logic        cap_hs  [NMAX];
  logic        cap_vld [NMAX];
  logic [19:0] cap_cnt [NMAX];

  always #5 clk = ~clk;

  wb_gain_ppc #(
    .DW_IN(10), .DW_GAIN(10), .DW_DEC(8), .PPC(2), .DW_CNT(20)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .CFA        (cfa),
    .wb_en      (wb_en),
    .vsync_in   (vsync_in),
    .hsync_in   (hsync_in),
    .data_in    (data_in),
    .R_gain     (r_gain),
    .Gr_gain    (gr_gain),
    .Gb_gain    (gb_gain),
    .B_gain     (b_gain),
    .vsync_out  (vsync_out),
    .hsync_out  (hsync_out),
    .data_out   (data_out),
    .sat_cnt    (sat_cnt),
    .sat_cnt_vld(sat_cnt_vld)
  );

  function automatic logic [19:0] px(input logic [9:0] left, input logic [9:0] right);
    return {left, right};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic en, input logic [1:0] c, input logic [9:0] gr_r,
                     input logic [9:0] g_gr, input logic [9:0] g_gb, input logic [9:0] g_b);
    wb_en   = en;
    cfa     = c;
    r_gain  = gr_r;
    gr_gain = g_gr;
    gb_gain = g_gb;
    b_gain  = g_b;
  endtask

  task automatic add(input logic vs, input logic hs, input logic [19:0] d);
    st_vs[n_st] = vs;
    st_hs[n_st] = hs;
    st_d[n_st]  = d;
    n_st++;
  endtask

  // Frame: start cycle (idx 0), lines of beats each followed by one gap beat, three idle beats.
  task automatic build_frame(input int lines, input int beats, input logic [19:0] d);
    n_st = 0;
    add(1'b1, 1'b0, 20'd0);
    for (int l = 0; l < lines; l++) begin
      for (int b = 0; b < beats; b++) add(1'b1, 1'b1, d);
      add(1'b1, 1'b0, 20'd0);
    end
    for (int k = 0; k < 3; k++) add(1'b0, 1'b0, 20'd0);
  endtask

  // Play the script; optionally change R_gain at script cycle rg_cyc.
  task automatic run(input int rg_cyc, input logic [9:0] rg_val);
    for (int c = 0; c <= n_st; c++) begin
      if (c < n_st) begin
        vsync_in = st_vs[c];
        hsync_in = st_hs[c];
        data_in  = st_d[c];
      end else begin
        vsync_in = 1'b0;
        hsync_in = 1'b0;
        data_in  = 20'd0;
      end
      if (c == rg_cyc) r_gain = rg_val;
      tick();
      if (c >= 1) begin
        cap_d[c-1]   = data_out;
        cap_vs[c-1]  = vsync_out;
        cap_hs[c-1]  = hsync_out;
        cap_vld[c-1] = sat_cnt_vld;
        cap_cnt[c-1] = sat_cnt;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cfg(1'b1, 2'b01, 10'd512, 10'd512, 10'd512, 10'd512);
    vsync_in = 1'b1;
    hsync_in = 1'b1;
    data_in  = px(10'd600, 10'd600);
    tick();
    tick();
    total++; if (data_out !== 20'd0) begin bad++; $display("FAIL reset_data got %h want 0", data_out); end
    total++; if (vsync_out !== 1'b0) begin bad++; $display("FAIL reset_vsync got %b want 0", vsync_out); end
    total++; if (hsync_out !== 1'b0) begin bad++; $display("FAIL reset_hsync got %b want 0", hsync_out); end
    total++; if (sat_cnt !== 20'd0) begin bad++; $display("FAIL reset_sat_cnt got %0d want 0", sat_cnt); end
    total++; if (sat_cnt_vld !== 1'b0) begin bad++; $display("FAIL reset_vld got %b want 0", sat_cnt_vld); end
    rst_n    = 1'b1;
    vsync_in = 1'b0;
    hsync_in = 1'b0;
    data_in  = 20'd0;
    repeat (3) tick();
  endtask

  task automatic test_unity();
    cfg(1'b1, 2'b00, 10'd256, 10'd256, 10'd256, 10'd256);
    n_st = 0;
    for (int i = 0; i < 12; i++)
      add(i < 10, (i >= 1) && (i < 9), px(10'((i * 73) % 1024), 10'((i * 73 + 500) % 1024)));
    run(-1, 10'd0);
    for (int i = 0; i < 12; i++) begin
      total++; if (cap_d[i] !== st_d[i]) begin bad++; $display("FAIL unity_data[%0d] got %h want %h", i, cap_d[i], st_d[i]); end
      total++; if (cap_vs[i] !== st_vs[i]) begin bad++; $display("FAIL unity_vsync[%0d] got %b want %b", i, cap_vs[i], st_vs[i]); end
      total++; if (cap_hs[i] !== st_hs[i]) begin bad++; $display("FAIL unity_hsync[%0d] got %b want %b", i, cap_hs[i], st_hs[i]); end
    end
    total++; if (cap_vld[11] !== 1'b1) begin bad++; $display("FAIL unity_vld got %b want 1", cap_vld[11]); end
    total++; if (cap_cnt[11] !== 20'd0) begin bad++; $display("FAIL unity_sat_cnt got %0d want 0", cap_cnt[11]); end
  endtask

  task automatic test_round();
    cfg(1'b1, 2'b01, 10'd384, 10'd256, 10'd256, 10'd256);
    build_frame(1, 2, 20'd0);
    st_d[1] = px(10'd3, 10'd7);
    st_d[2] = px(10'd2, 10'd9);
    run(-1, 10'd0);
    // 3*1.5=4.5 -> 5 ; 2*1.5=3.0 -> 3 ; greens at unity.
    total++; if (cap_d[1] !== px(10'd5, 10'd7)) begin bad++; $display("FAIL round_a got %h want %h", cap_d[1], px(10'd5, 10'd7)); end
    total++; if (cap_d[2] !== px(10'd3, 10'd9)) begin bad++; $display("FAIL round_b got %h want %h", cap_d[2], px(10'd3, 10'd9)); end
  endtask

  // R=1.0 Gr=2.0 Gb=3.0 B=0.5 on pixels of 100 -> R 100, Gr 200, Gb 300, B 50.
  task automatic test_channels(input logic [1:0] c, input logic [9:0] a0, input logic [9:0] b0,
                               input logic [9:0] a1, input logic [9:0] b1);
    logic [19:0] exp_d;
    cfg(1'b1, c, 10'd256, 10'd512, 10'd768, 10'd128);
    build_frame(3, 2, px(10'd100, 10'd100));
    run(-1, 10'd0);
    for (int l = 0; l < 3; l++) begin
      for (int b = 0; b < 2; b++) begin
        exp_d = (l % 2 == 0) ? px(a0, b0) : px(a1, b1);
        total++;
        if (cap_d[1 + l * 3 + b] !== exp_d) begin
          bad++;
          $display("FAIL chan_cfa%0d_row%0d_beat%0d got %h want %h", c, l, b, cap_d[1 + l * 3 + b], exp_d);
        end
      end
    end
  endtask

  task automatic test_mid_frame_gain();
    cfg(1'b1, 2'b01, 10'd256, 10'd256, 10'd256, 10'd256);
    build_frame(2, 2, px(10'd100, 10'd100));
    run(2, 10'd512);
    for (int i = 1; i <= 5; i++) begin
      if (i == 3) continue;
      total++; if (cap_d[i] !== px(10'd100, 10'd100)) begin bad++; $display("FAIL midgain_old[%0d] got %h want %h", i, cap_d[i], px(10'd100, 10'd100)); end
    end
    build_frame(2, 2, px(10'd100, 10'd100));
    run(-1, 10'd0);
    for (int b = 1; b <= 2; b++) begin
      total++; if (cap_d[b] !== px(10'd200, 10'd100)) begin bad++; $display("FAIL midgain_new_r[%0d] got %h want %h", b, cap_d[b], px(10'd200, 10'd100)); end
      total++; if (cap_d[b+3] !== px(10'd100, 10'd100)) begin bad++; $display("FAIL midgain_new_b[%0d] got %h want %h", b, cap_d[b+3], px(10'd100, 10'd100)); end
    end
  endtask

  task automatic test_sat_count();
    cfg(1'b1, 2'b01, 10'd512, 10'd512, 10'd512, 10'd512);
    build_frame(1, 5, px(10'd600, 10'd600));
    run(-1, 10'd0);
    for (int i = 1; i <= 5; i++) begin
      total++; if (cap_d[i] !== px(10'd1023, 10'd1023)) begin bad++; $display("FAIL sat_data[%0d] got %h want %h", i, cap_d[i], px(10'd1023, 10'd1023)); end
    end
    total++; if (cap_vld[7] !== 1'b0) begin bad++; $display("FAIL sat_vld_early got %b want 0", cap_vld[7]); end
    total++; if (cap_vld[8] !== 1'b1) begin bad++; $display("FAIL sat_vld got %b want 1", cap_vld[8]); end
    total++; if (cap_cnt[8] !== 20'd10) begin bad++; $display("FAIL sat_cnt got %0d want 10", cap_cnt[8]); end
    total++; if (cap_vld[9] !== 1'b0) begin bad++; $display("FAIL sat_vld_late got %b want 0", cap_vld[9]); end
    total++; if (cap_cnt[9] !== 20'd10) begin bad++; $display("FAIL sat_cnt_hold got %0d want 10", cap_cnt[9]); end
  endtask

  task automatic test_midline_reset();
    logic seen_vld;
    cfg(1'b1, 2'b01, 10'd512, 10'd512, 10'd512, 10'd512);
    vsync_in = 1'b1; hsync_in = 1'b0; data_in = 20'd0;
    tick();
    hsync_in = 1'b1; data_in = px(10'd600, 10'd600);
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    total++; if (data_out !== 20'd0) begin bad++; $display("FAIL mrst_data got %h want 0", data_out); end
    total++; if (vsync_out !== 1'b0) begin bad++; $display("FAIL mrst_vsync got %b want 0", vsync_out); end
    total++; if (hsync_out !== 1'b0) begin bad++; $display("FAIL mrst_hsync got %b want 0", hsync_out); end
    total++; if (sat_cnt !== 20'd0) begin bad++; $display("FAIL mrst_sat_cnt got %0d want 0", sat_cnt); end
    total++; if (sat_cnt_vld !== 1'b0) begin bad++; $display("FAIL mrst_vld got %b want 0", sat_cnt_vld); end
    rst_n = 1'b1;
    tick();
    tick();
    // No new frame start was seen, so reset shadows (pass-through) still apply.
    total++; if (data_out !== px(10'd600, 10'd600)) begin bad++; $display("FAIL mrst_passthru got %h want %h", data_out, px(10'd600, 10'd600)); end
    seen_vld = 1'b0;
    repeat (2) begin tick(); if (sat_cnt_vld) seen_vld = 1'b1; end
    vsync_in = 1'b0; hsync_in = 1'b0; data_in = 20'd0;
    repeat (5) begin tick(); if (sat_cnt_vld) seen_vld = 1'b1; end
    total++; if (seen_vld !== 1'b0) begin bad++; $display("FAIL mrst_no_vld got %b want 0", seen_vld); end
    total++; if (sat_cnt !== 20'd0) begin bad++; $display("FAIL mrst_cnt_after got %0d want 0", sat_cnt); end
  endtask

  task automatic test_wb_disable();
    cfg(1'b0, 2'b01, 10'd512, 10'd512, 10'd512, 10'd512);
    build_frame(1, 5, px(10'd600, 10'd600));
    run(-1, 10'd0);
    for (int i = 1; i <= 5; i++) begin
      total++; if (cap_d[i] !== px(10'd600, 10'd600)) begin bad++; $display("FAIL wboff_data[%0d] got %h want %h", i, cap_d[i], px(10'd600, 10'd600)); end
    end
    total++; if (cap_vld[8] !== 1'b1) begin bad++; $display("FAIL wboff_vld got %b want 1", cap_vld[8]); end
    total++; if (cap_cnt[8] !== 20'd0) begin bad++; $display("FAIL wboff_sat_cnt got %0d want 0", cap_cnt[8]); end
  endtask

  initial begin
    rst_n    = 1'b0;
    vsync_in = 1'b0;
    hsync_in = 1'b0;
    data_in  = 20'd0;
    cfg(1'b0, 2'b00, 10'd0, 10'd0, 10'd0, 10'd0);
    test_reset();
    test_unity();
    test_round();
    test_channels(2'b01, 10'd100, 10'd200, 10'd300, 10'd50);
    test_channels(2'b00, 10'd200, 10'd100, 10'd50, 10'd300);
    test_channels(2'b10, 10'd50, 10'd300, 10'd200, 10'd100);
    test_channels(2'b11, 10'd300, 10'd50, 10'd100, 10'd200);
    test_mid_frame_gain();
    test_sat_count();
    test_midline_reset();
    test_wb_disable();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
